// File: rtl/obi_pkg.sv
// Shared OBI bus widths, response-stage record and init FSM states used by the
// OBI SRAM endpoint and its response pipeline.
package obi_pkg;

  localparam int unsigned OBI_DW  = 32;
  localparam int unsigned OBI_AW  = 32;
  localparam int unsigned OBI_BEW = 4;

  typedef struct packed {
    logic valid;
    logic is_read;
    logic err;
  } obi_rsp_t;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } init_state_e;

endpackage

// File: rtl/obi_if.sv
// OBI request/response bus; the master drives requests, the slave grants and
// returns one response per granted transaction.
interface obi_if;
  import obi_pkg::*;

  logic                req;
  logic                gnt;
  logic [OBI_AW-1:0]   addr;
  logic                we;
  logic [OBI_BEW-1:0]  be;
  logic [OBI_DW-1:0]   wdata;
  logic                rvalid;
  logic [OBI_DW-1:0]   rdata;
  logic                err;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/obi_rsp_pipe.sv
// Fixed-depth shift register of OBI response records; shifts every cycle and
// is cleared by reset so that in-flight responses are dropped.
module obi_rsp_pipe
  import obi_pkg::*;
#(
  parameter int unsigned STAGES = 1
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  obi_rsp_t rsp_i,
  output obi_rsp_t rsp_o
);

  obi_rsp_t stage_q [STAGES];
  obi_rsp_t stage_d [STAGES];

  always_comb begin
    stage_d[0] = rsp_i;
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign rsp_o = stage_q[STAGES-1];

endmodule

// File: rtl/obi_to_sram.sv
// OBI slave endpoint terminating onto a single-port OpenRAM-style SRAM macro.
// Define OBI_SRAM_INIT_EN to zero-fill the SRAM after reset before any grant.
module obi_to_sram
  import obi_pkg::*;
#(
  parameter int unsigned        DEPTH        = 256,
  parameter logic [OBI_AW-1:0]  BASE_ADDR    = 32'h3000_0000,
  parameter int unsigned        READ_LATENCY = 1,
  localparam int unsigned       AW           = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  obi_if.slave                obi,
  output logic                init_done_o,
  output logic                sram_csb_o,
  output logic                sram_web_o,
  output logic [OBI_BEW-1:0]  sram_wmask_o,
  output logic [AW-1:0]       sram_addr_o,
  output logic [OBI_DW-1:0]   sram_din_o,
  input  logic [OBI_DW-1:0]   sram_dout_i
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("obi_to_sram: DEPTH must be a power of two and at least 2");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_latency
    $error("obi_to_sram: READ_LATENCY must be in 1..3");
  end
  if (BASE_ADDR[AW+1:0] != '0) begin : g_bad_base
    $error("obi_to_sram: BASE_ADDR must be aligned to the window size");
  end

  logic          in_range;
  logic [AW-1:0] word_idx;
  logic          hs;
  logic          init_wr;
  logic [AW-1:0] init_addr;
  logic          unused_addr_lsb;

  // Byte offset within a word carries no meaning for a 32-bit SRAM.
  assign unused_addr_lsb = ^obi.addr[1:0];

  always_comb begin
    in_range = (obi.addr[OBI_AW-1:AW+2] == BASE_ADDR[OBI_AW-1:AW+2]);
    word_idx = obi.addr[AW+1:2];
    obi.gnt  = obi.req && init_done_o;
    hs       = obi.req && init_done_o;
  end

`ifdef OBI_SRAM_INIT_EN
  init_state_e   state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + AW'(1);
      if (cnt_q == AW'(DEPTH - 1)) begin
        state_d = READY;
      end
    end
  end

  always_comb begin
    init_done_o = (state_q == READY);
    init_wr     = (state_q == INIT);
    init_addr   = cnt_q;
  end
`else
  logic init_done_q, init_done_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      init_done_q <= 1'b0;
    end else begin
      init_done_q <= init_done_d;
    end
  end

  always_comb begin
    init_done_d = 1'b1;
    init_done_o = init_done_q;
    init_wr     = 1'b0;
    init_addr   = '0;
  end
`endif

  // Out-of-range handshakes keep the macro deselected; only the response flags them.
  always_comb begin
    sram_csb_o   = 1'b1;
    sram_web_o   = 1'b1;
    sram_wmask_o = '0;
    sram_addr_o  = word_idx;
    sram_din_o   = obi.wdata;
    if (init_wr) begin
      sram_csb_o   = 1'b0;
      sram_web_o   = 1'b0;
      sram_wmask_o = '1;
      sram_addr_o  = init_addr;
      sram_din_o   = '0;
    end else if (hs && in_range) begin
      sram_csb_o   = 1'b0;
      sram_web_o   = !obi.we;
      sram_wmask_o = obi.be;
    end
  end

  obi_rsp_t rsp_in, rsp_out;

  always_comb begin
    rsp_in.valid   = hs;
    rsp_in.is_read = !obi.we;
    rsp_in.err     = !in_range;
  end

  obi_rsp_pipe #(
    .STAGES (READ_LATENCY)
  ) u_rsp_pipe (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .rsp_i (rsp_in),
    .rsp_o (rsp_out)
  );

  // The pipeline depth matches the macro latency, so dout lines up with its response.
  always_comb begin
    obi.rvalid = rsp_out.valid;
    obi.err    = rsp_out.valid && rsp_out.err;
    obi.rdata  = '0;
    if (rsp_out.valid && rsp_out.is_read && !rsp_out.err) begin
      obi.rdata = sram_dout_i;
    end
  end

endmodule

// File: tb/tb_obi_to_sram.sv
// Bench for obi_to_sram: two instances (read latency 1 and 3) share one stimulus
// stream and are checked every cycle against a transaction-level memory model.
module tb_obi_to_sram;

  localparam int          DEPTH = 256;
  localparam int          AW    = 8;
  localparam logic [31:0] BASE  = 32'h3000_0000;
`ifdef OBI_SRAM_INIT_EN
  localparam int INIT_CYCLES = DEPTH;
`else
  localparam int INIT_CYCLES = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   = 1'b1;
  logic        req   = 1'b0;
  logic        we    = 1'b0;
  logic [3:0]  be    = 4'h0;
  logic [31:0] addr  = BASE;
  logic [31:0] wdata = 32'h0;

  obi_if bus1 ();
  obi_if bus3 ();

  assign bus1.req = req;   assign bus3.req = req;
  assign bus1.we = we;     assign bus3.we = we;
  assign bus1.be = be;     assign bus3.be = be;
  assign bus1.addr = addr; assign bus3.addr = addr;
  assign bus1.wdata = wdata; assign bus3.wdata = wdata;

  logic          init1, csb1, web1, init3, csb3, web3;
  logic [3:0]    wm1, wm3;
  logic [AW-1:0] sa1, sa3;
  logic [31:0]   din1, din3;
  logic [31:0]   dout1 = 32'h0, dout3 = 32'h0;

  obi_to_sram #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .READ_LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .obi(bus1), .init_done_o(init1),
    .sram_csb_o(csb1), .sram_web_o(web1), .sram_wmask_o(wm1),
    .sram_addr_o(sa1), .sram_din_o(din1), .sram_dout_i(dout1)
  );

  obi_to_sram #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .READ_LATENCY(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .obi(bus3), .init_done_o(init3),
    .sram_csb_o(csb3), .sram_web_o(web3), .sram_wmask_o(wm3),
    .sram_addr_o(sa3), .sram_din_o(din3), .sram_dout_i(dout3)
  );

  function automatic logic [31:0] pat(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // SRAM macro models (environment, not reference)
  logic [31:0] mem1 [DEPTH];
  logic [31:0] mem3 [DEPTH];
  logic [31:0] p3a = 32'h0, p3b = 32'h0;
  bit ld1 = 1'b0, ld3 = 1'b0;

  always @(posedge clk) begin
    if (!ld1) begin
      for (int i = 0; i < DEPTH; i++) mem1[i] <= pat(i);
      ld1 <= 1'b1;
    end else if (!csb1) begin
      if (!web1)
        for (int b = 0; b < 4; b++) if (wm1[b]) mem1[sa1][8*b +: 8] <= din1[8*b +: 8];
      dout1 <= mem1[sa1];
    end
  end

  always @(posedge clk) begin
    if (!ld3) begin
      for (int i = 0; i < DEPTH; i++) mem3[i] <= pat(i);
      ld3 <= 1'b1;
    end else if (!csb3) begin
      if (!web3)
        for (int b = 0; b < 4; b++) if (wm3[b]) mem3[sa3][8*b +: 8] <= din3[8*b +: 8];
      p3a <= mem3[sa3];
    end
    p3b   <= p3a;
    dout3 <= p3b;
  end

  int cyc = 0;
  int rel = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rel <= rst ? 0 : rel + 1;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: word memory plus expected-response queues with due cycles.
  typedef struct {
    int          due;
    logic        vld;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        q1[$], q3[$];
  logic [31:0] mref [DEPTH];
  int          n_rv1 = 0, n_rv3 = 0;
  int          rv1_q[$], rv3_q[$];
  logic [31:0] last1_rdata = 32'h0, last3_rdata = 32'h0;
  logic        last1_err = 1'b0, last3_err = 1'b0;

  logic          init_e, gnt_e, inr_e, ip_e, csb_e, web_e;
  logic [3:0]    wm_e;
  logic [AW-1:0] sa_e, idx_e;
  logic [31:0]   din_e;
  exp_t          e;

  initial begin : model
    for (int i = 0; i < DEPTH; i++) mref[i] = pat(i);
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_rvalid1", bus1.rvalid, 1'b0); chk("rst_rvalid3", bus3.rvalid, 1'b0);
        chk("rst_err1", bus1.err, 1'b0);       chk("rst_err3", bus3.err, 1'b0);
        chk("rst_rdata1", bus1.rdata, 32'h0);  chk("rst_rdata3", bus3.rdata, 32'h0);
        chk("rst_csb1", csb1, 1'b1);           chk("rst_csb3", csb3, 1'b1);
        chk("rst_web1", web1, 1'b1);           chk("rst_web3", web3, 1'b1);
        chk("rst_wmask1", wm1, 4'h0);          chk("rst_wmask3", wm3, 4'h0);
        chk("rst_init1", init1, 1'b0);         chk("rst_init3", init3, 1'b0);
        chk("rst_gnt1", bus1.gnt, 1'b0);       chk("rst_gnt3", bus3.gnt, 1'b0);
        q1.delete();
        q3.delete();
`ifdef OBI_SRAM_INIT_EN
        for (int i = 0; i < DEPTH; i++) mref[i] = 32'h0;
`endif
      end else begin
        init_e = (rel >= INIT_CYCLES);
        gnt_e  = req && init_e;
        inr_e  = (addr[31:AW+2] == BASE[31:AW+2]);
        idx_e  = addr[AW+1:2];
`ifdef OBI_SRAM_INIT_EN
        ip_e = !init_e;
`else
        ip_e = 1'b0;
`endif
        if (ip_e) begin
          csb_e = 1'b0; web_e = 1'b0; wm_e = 4'hF; sa_e = rel[AW-1:0]; din_e = 32'h0;
        end else begin
          csb_e = !(gnt_e && inr_e); web_e = !we; wm_e = be; sa_e = idx_e; din_e = wdata;
        end
        chk("gnt1", bus1.gnt, gnt_e);   chk("gnt3", bus3.gnt, gnt_e);
        chk("init1", init1, init_e);    chk("init3", init3, init_e);
        chk("csb1", csb1, csb_e);       chk("csb3", csb3, csb_e);
        if (!csb_e) begin
          chk("web1", web1, web_e);     chk("web3", web3, web_e);
          chk("wmask1", wm1, wm_e);     chk("wmask3", wm3, wm_e);
          chk("saddr1", sa1, sa_e);     chk("saddr3", sa3, sa_e);
          chk("din1", din1, din_e);     chk("din3", din3, din_e);
        end

        if (q1.size() > 0 && q1[0].due == cyc) e = q1.pop_front();
        else begin e.vld = 1'b0; e.err = 1'b0; e.rdata = 32'h0; end
        chk("rvalid1", bus1.rvalid, e.vld);
        chk("err1", bus1.err, e.err);
        chk("rdata1", bus1.rdata, e.rdata);

        if (q3.size() > 0 && q3[0].due == cyc) e = q3.pop_front();
        else begin e.vld = 1'b0; e.err = 1'b0; e.rdata = 32'h0; end
        chk("rvalid3", bus3.rvalid, e.vld);
        chk("err3", bus3.err, e.err);
        chk("rdata3", bus3.rdata, e.rdata);

        if (bus1.rvalid) begin
          n_rv1++; last1_rdata = bus1.rdata; last1_err = bus1.err; rv1_q.push_back(cyc);
        end
        if (bus3.rvalid) begin
          n_rv3++; last3_rdata = bus3.rdata; last3_err = bus3.err; rv3_q.push_back(cyc);
        end

        if (gnt_e) begin
          e.vld   = 1'b1;
          e.err   = !inr_e;
          e.rdata = (inr_e && !we) ? mref[idx_e] : 32'h0;
          e.due   = cyc + 1; q1.push_back(e);
          e.due   = cyc + 3; q3.push_back(e);
          if (inr_e && we)
            for (int b = 0; b < 4; b++) if (be[b]) mref[idx_e][8*b +: 8] = wdata[8*b +: 8];
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d);
    req = r; we = w; addr = a; be = b; wdata = d;
  endtask

  task automatic txn(input logic w, input logic [31:0] a, input logic [3:0] b,
                     input logic [31:0] d);
    drive(1'b1, w, a, b, d);
    step();
    drive(1'b0, 1'b0, BASE, 4'h0, 32'h0);
  endtask

  task automatic settle();
    repeat (5) step();
  endtask

  initial begin : stim
    int n1, n3, cs, k;
    logic [31:0] a;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    // Read of word 16 with req held high from reset release.
    drive(1'b1, 1'b0, BASE + 32'h40, 4'hF, 32'h0);
    #1;
    k = 0;
    while (!bus1.gnt && k < INIT_CYCLES + 10) begin step(); k++; end
    chk("first_grant_wait", k, INIT_CYCLES);
    step();
    drive(1'b0, 1'b0, BASE, 4'h0, 32'h0);
    settle();
`ifdef OBI_SRAM_INIT_EN
    chk("init_zero_rdata", last1_rdata, 32'h0);
`else
    chk("preload_rdata", last1_rdata, pat(16));
`endif

    // Full write then read back.
    n1 = n_rv1;
    txn(1'b1, BASE + 32'h10, 4'hF, 32'hDEAD_BEEF);
    settle();
    chk("wr_rsp_count", n_rv1 - n1, 1);
    chk("wr_rsp_err", last1_err, 1'b0);
    chk("wr_rsp_rdata", last1_rdata, 32'h0);
    chk("model_word4", mref[4], 32'hDEAD_BEEF);
    txn(1'b0, BASE + 32'h10, 4'hF, 32'h0);
    settle();
    chk("rd_deadbeef1", last1_rdata, 32'hDEAD_BEEF);
    chk("rd_deadbeef3", last3_rdata, 32'hDEAD_BEEF);

    // Partial write over all-ones.
    txn(1'b1, BASE + 32'h20, 4'hF, 32'hFFFF_FFFF);
    txn(1'b1, BASE + 32'h20, 4'b0011, 32'h1234_5678);
    txn(1'b0, BASE + 32'h20, 4'hF, 32'h0);
    settle();
    chk("model_word8", mref[8], 32'hFFFF_5678);
    chk("rd_partial1", last1_rdata, 32'hFFFF_5678);
    chk("rd_partial3", last3_rdata, 32'hFFFF_5678);

    // Back-to-back reads of four consecutive words.
    rv1_q.delete();
    rv3_q.delete();
    cs = cyc;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, BASE + 32'h10 + 32'(4 * i), 4'hF, 32'h0);
      step();
    end
    drive(1'b0, 1'b0, BASE, 4'h0, 32'h0);
    settle();
    chk("burst_count1", rv1_q.size(), 4);
    chk("burst_count3", rv3_q.size(), 4);
    if (rv1_q.size() == 4 && rv3_q.size() == 4) begin
      chk("burst_first1", rv1_q[0] - cs, 1);
      chk("burst_gapless1", rv1_q[3] - rv1_q[0], 3);
      chk("burst_first3", rv3_q[0] - cs, 3);
      chk("burst_gapless3", rv3_q[3] - rv3_q[0], 3);
    end

    // Out-of-range read.
    txn(1'b0, 32'h3000_0400, 4'hF, 32'h0);
    settle();
    chk("oor_err1", last1_err, 1'b1);
    chk("oor_rdata1", last1_rdata, 32'h0);
    chk("oor_err3", last3_err, 1'b1);

    // Reset one cycle after a read grant drops the response.
    n1 = n_rv1;
    n3 = n_rv3;
    txn(1'b0, BASE + 32'h10, 4'hF, 32'h0);
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    #1;
    chk("post_rst_rvalid1", bus1.rvalid, 1'b0);
    chk("post_rst_rvalid3", bus3.rvalid, 1'b0);
    chk("post_rst_csb1", csb1 | init3 | init1, INIT_CYCLES == 1 ? 1'b1 : 1'b0);
    k = 0;
    while (!init1 && k < INIT_CYCLES + 10) begin step(); k++; end
    chk("reinit_wait", k, INIT_CYCLES);
    settle();
    chk("rst_drop1", n_rv1 - n1, 0);
    chk("rst_drop3", n_rv3 - n3, 0);

    // Randomized traffic over a small window plus occasional out-of-range hits.
    for (int i = 0; i < 600; i++) begin
      a = BASE + (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a ^ (32'h1 << $urandom_range(10, 31));
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a, 4'($urandom), $urandom);
      step();
    end
    drive(1'b0, 1'b0, BASE, 4'h0, 32'h0);
    settle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: bench did not reach its end, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
